// File: rtl/clk_div_pkg.sv
// Shared types and reset constants for the multi-channel clock/strobe divider.
// The cfg struct is sized by DIV_W_DEF; widen it here when a wider divider is needed.
package clk_div_pkg;

    localparam int DIV_W_DEF   = 16;
    localparam int DIV_RST_DEF = 49;
    localparam int HI_RST_DEF  = 25;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] div;
        logic [DIV_W_DEF-1:0] hi;
    } div_cfg_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Output level for a given phase: high while the phase is below the high time.
    function automatic logic level_at(input logic [DIV_W_DEF-1:0] phase,
                                      input logic [DIV_W_DEF-1:0] hi);
        return phase < hi;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: phase counter, shadow/active config and registered level/strobes.
// Config changes only land at a period boundary, start or sync, so no runt pulses appear.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int   DIV_RST    = DIV_RST_DEF,
    parameter int   HI_RST     = HI_RST_DEF,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic     sys_clk,
    input  logic     rst_n,
    input  logic     en,
    input  logic     sync,
    input  logic     cfg_wr,
    input  div_cfg_t cfg_in,
    output logic     clk_out,
    output logic     tick,
    output logic     rise_stb,
    output logic     fall_stb,
    output logic     cfg_pending
);

    localparam div_cfg_t CFG_RST = {DIV_W_DEF'(DIV_RST), DIV_W_DEF'(HI_RST)};

    ch_state_t            state;
    ch_state_t            state_next;
    logic [DIV_W_DEF-1:0] cnt;
    logic [DIV_W_DEF-1:0] cnt_next;
    div_cfg_t             act_cfg;
    div_cfg_t             act_next;
    div_cfg_t             shadow;
    div_cfg_t             shadow_next;
    div_cfg_t             apply_cfg;
    logic                 pending_next;
    logic                 tick_next;
    logic                 clk_next;
    logic                 rise_next;
    logic                 fall_next;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state       <= CH_IDLE;
            cnt         <= '0;
            act_cfg     <= CFG_RST;
            shadow      <= CFG_RST;
            cfg_pending <= 1'b0;
            clk_out     <= IDLE_LEVEL;
            tick        <= 1'b0;
            rise_stb    <= 1'b0;
            fall_stb    <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            act_cfg     <= act_next;
            shadow      <= shadow_next;
            cfg_pending <= pending_next;
            clk_out     <= clk_next;
            tick        <= tick_next;
            rise_stb    <= rise_next;
            fall_stb    <= fall_next;
        end
    end

    // A write landing on the same edge as an apply point is used directly (write-through).
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        act_next     = act_cfg;
        shadow_next  = shadow;
        pending_next = cfg_pending;
        tick_next    = 1'b0;
        clk_next     = IDLE_LEVEL;
        apply_cfg    = cfg_wr ? cfg_in : shadow;

        if (cfg_wr) begin
            shadow_next  = cfg_in;
            pending_next = 1'b1;
        end

        if (!en) begin
            state_next = CH_IDLE;
            cnt_next   = '0;
        end else if (state == CH_IDLE || sync) begin
            state_next   = CH_RUN;
            cnt_next     = '0;
            tick_next    = 1'b1;
            act_next     = apply_cfg;
            pending_next = 1'b0;
        end else if (cnt == act_cfg.div) begin
            cnt_next  = '0;
            tick_next = 1'b1;
            if (cfg_pending || cfg_wr) begin
                act_next = apply_cfg;
            end
            pending_next = 1'b0;
        end else begin
            cnt_next = cnt + DIV_W_DEF'(1);
        end

        if (en) begin
            clk_next = level_at(cnt_next, act_next.hi);
        end

        rise_next = clk_next & ~clk_out;
        fall_next = ~clk_next & clk_out;
    end

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock/strobe generator; clk_out is a logic level, never a clock net.
// The top only fans the shared sync and config bus out to independent channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int   N_CH       = 2,
    parameter int   DIV_W      = DIV_W_DEF,
    parameter int   DIV_RST    = DIV_RST_DEF,
    parameter int   HI_RST     = HI_RST_DEF,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic [N_CH-1:0]  cfg_wr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_hi,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  rise_stb,
    output logic [N_CH-1:0]  fall_stb,
    output logic [N_CH-1:0]  cfg_pending
);

    div_cfg_t cfg_bus;

    assign cfg_bus = {cfg_div, cfg_hi};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_RST    (DIV_RST),
            .HI_RST     (HI_RST),
            .IDLE_LEVEL (IDLE_LEVEL)
        ) u_ch (
            .sys_clk     (sys_clk),
            .rst_n       (rst_n),
            .en          (en[i]),
            .sync        (sync),
            .cfg_wr      (cfg_wr[i]),
            .cfg_in      (cfg_bus),
            .clk_out     (clk_out[i]),
            .tick        (tick[i]),
            .rise_stb    (rise_stb[i]),
            .fall_stb    (fall_stb[i]),
            .cfg_pending (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: both channels are compared every cycle against an
// expected waveform built from the programmed period/high time and known phase.
module tb_clk_div_multi;

    localparam logic IDLE = 1'b1;

    logic        sys_clk;
    logic        rst_n;
    logic [1:0]  en;
    logic        sync;
    logic [1:0]  cfg_wr;
    logic [15:0] cfg_div;
    logic [15:0] cfg_hi;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  rise_stb;
    logic [1:0]  fall_stb;
    logic [1:0]  cfg_pending;

    int   check_count = 0;
    int   error_count = 0;
    logic act  [2];
    int   ph   [2];
    int   per  [2];
    int   hiv  [2];
    logic prev [2];

    clk_div_multi dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync        (sync),
        .cfg_wr      (cfg_wr),
        .cfg_div     (cfg_div),
        .cfg_hi      (cfg_hi),
        .clk_out     (clk_out),
        .tick        (tick),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .cfg_pending (cfg_pending)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Advance n clocks; after each edge compare {tick,clk_out,rise,fall} of both channels.
    task automatic applyStimulus(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            #1;
            for (int c = 0; c < 2; c++) begin
                logic       lvl;
                logic       exp_tick;
                logic [3:0] exp_v;
                logic [3:0] got_v;
                if (act[c]) begin
                    lvl      = (ph[c] < hiv[c]);
                    exp_tick = (ph[c] == 0);
                end else begin
                    lvl      = IDLE;
                    exp_tick = 1'b0;
                end
                exp_v = {exp_tick, lvl, lvl & ~prev[c], ~lvl & prev[c]};
                got_v = {tick[c], clk_out[c], rise_stb[c], fall_stb[c]};
                checkOutput($sformatf("%s ch%0d cyc%0d", tag, c, k), 32'(got_v), 32'(exp_v));
                prev[c] = lvl;
                if (act[c]) ph[c] = (ph[c] + 1 == per[c]) ? 0 : ph[c] + 1;
            end
        end
    endtask

    task automatic writeCfg(input logic [1:0] wr, input int d, input int h);
        cfg_wr  = wr;
        cfg_div = 16'(d);
        cfg_hi  = 16'(h);
    endtask

    initial begin
        rst_n = 1'b0; en = 2'b00; sync = 1'b0; cfg_wr = 2'b00; cfg_div = '0; cfg_hi = '0;
        for (int c = 0; c < 2; c++) begin
            act[c] = 1'b0; ph[c] = 0; per[c] = 50; hiv[c] = 25; prev[c] = IDLE;
        end
        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("rst clk_out", 32'(clk_out), 32'h3);
        checkOutput("rst tick", 32'(tick), 32'h0);
        checkOutput("rst rise", 32'(rise_stb), 32'h0);
        checkOutput("rst fall", 32'(fall_stb), 32'h0);
        checkOutput("rst pending", 32'(cfg_pending), 32'h0);

        $display("[TB] default 50-cycle period on ch0");
        rst_n = 1'b1; en = 2'b01; act[0] = 1'b1; ph[0] = 0;
        applyStimulus("base", 100);
        applyStimulus("pre", 10);

        $display("[TB] mid-period reconfig div=3 hi=1");
        writeCfg(2'b01, 3, 1);
        applyStimulus("wr", 1);
        cfg_wr = 2'b00;
        checkOutput("pend set", 32'(cfg_pending), 32'h1);
        applyStimulus("old", 39);
        checkOutput("pend hold", 32'(cfg_pending), 32'h1);
        per[0] = 4; hiv[0] = 1;
        applyStimulus("new", 1);
        checkOutput("pend clr", 32'(cfg_pending), 32'h0);
        applyStimulus("new", 11);

        $display("[TB] write on wrap cycle div=5 hi=2");
        writeCfg(2'b01, 5, 2);
        per[0] = 6; hiv[0] = 2;
        applyStimulus("wt", 1);
        cfg_wr = 2'b00;
        checkOutput("pend wt", 32'(cfg_pending), 32'h0);
        applyStimulus("wt", 11);

        $display("[TB] edge configs");
        writeCfg(2'b01, 0, 1);
        per[0] = 1; hiv[0] = 1;
        applyStimulus("div0", 1);
        cfg_wr = 2'b00;
        applyStimulus("div0", 10);
        writeCfg(2'b01, 4, 0);
        per[0] = 5; hiv[0] = 0;
        applyStimulus("hi0", 1);
        cfg_wr = 2'b00;
        applyStimulus("hi0", 9);
        writeCfg(2'b01, 2, 7);
        per[0] = 3; hiv[0] = 7;
        applyStimulus("hibig", 1);
        cfg_wr = 2'b00;
        applyStimulus("hibig", 8);

        $display("[TB] two channels and sync");
        writeCfg(2'b01, 9, 5);
        per[0] = 10; hiv[0] = 5;
        applyStimulus("c0cfg", 1);
        writeCfg(2'b10, 14, 7);
        applyStimulus("c1cfg", 1);
        cfg_wr = 2'b00;
        checkOutput("pend dis", 32'(cfg_pending), 32'h2);
        applyStimulus("off", 1);
        en = 2'b11; act[1] = 1'b1; ph[1] = 0; per[1] = 15; hiv[1] = 7;
        applyStimulus("c1on", 1);
        checkOutput("pend start", 32'(cfg_pending), 32'h0);
        applyStimulus("dual", 20);
        sync = 1'b1; ph[0] = 0; ph[1] = 0;
        applyStimulus("sync", 1);
        sync = 1'b0;
        checkOutput("sync tick", 32'(tick), 32'h3);
        applyStimulus("dual2", 30);
        en = 2'b01; act[1] = 1'b0;
        applyStimulus("c1off", 5);
        sync = 1'b1; ph[0] = 0;
        applyStimulus("sync2", 1);
        sync = 1'b0;
        checkOutput("sync dis tick", 32'(tick), 32'h1);
        applyStimulus("post", 5);

        $display("[TB] reset mid-period");
        en = 2'b00; act[0] = 1'b0;
        applyStimulus("stop", 2);
        writeCfg(2'b01, 49, 25);
        applyStimulus("idlewr", 1);
        cfg_wr = 2'b00;
        checkOutput("pend idle", 32'(cfg_pending), 32'h1);
        applyStimulus("idle", 1);
        en = 2'b01; act[0] = 1'b1; ph[0] = 0; per[0] = 50; hiv[0] = 25;
        applyStimulus("run50", 1);
        checkOutput("pend run50", 32'(cfg_pending), 32'h0);
        applyStimulus("run50", 15);
        writeCfg(2'b10, 7, 3);
        applyStimulus("run50", 1);
        cfg_wr = 2'b00;
        checkOutput("pend c1", 32'(cfg_pending), 32'h2);
        applyStimulus("run50", 1);
        rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        checkOutput("mid rst clk_out", 32'(clk_out), 32'h3);
        checkOutput("mid rst tick", 32'(tick), 32'h0);
        checkOutput("mid rst rise", 32'(rise_stb), 32'h0);
        checkOutput("mid rst fall", 32'(fall_stb), 32'h0);
        checkOutput("mid rst pending", 32'(cfg_pending), 32'h0);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        prev[0] = IDLE; prev[1] = IDLE; ph[0] = 0;
        applyStimulus("restart", 60);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
